// File: rtl/row_sequencer.sv
// row_sequencer: per-lane CSR row drain from FWFT len/val/col FIFOs onto registered valid/ready element streams.
// Optional: define ROW_SEQ_COUNT_EN to add rows_cnt, a per-lane 16-bit count of completed rows.
module row_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANES*DATA_W-1:0] val_in,
    input  logic [LANES*DATA_W-1:0] col_in,
    input  logic [LANES*DATA_W-1:0] len_in,
    input  logic [LANES-1:0]        val_empty,
    input  logic [LANES-1:0]        col_empty,
    input  logic [LANES-1:0]        len_empty,
    output logic [LANES-1:0]        val_read,
    output logic [LANES-1:0]        col_read,
    output logic [LANES-1:0]        len_read,
    output logic [LANES-1:0]        elem_valid,
    input  logic [LANES-1:0]        elem_ready,
    output logic [LANES*DATA_W-1:0] elem_val,
    output logic [LANES*DATA_W-1:0] elem_col,
    output logic [LANES-1:0]        elem_last,
    output logic [LANES-1:0]        row_done
`ifdef ROW_SEQ_COUNT_EN
    ,
    output logic [LANES*16-1:0]     rows_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ZERO, STREAM, DRAIN} state_t;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t            r_state;
        logic [DATA_W-1:0] r_rem, r_val, r_col;
        logic              r_valid, r_last, r_done;
        logic              w_len_rd, w_pop, w_acc, w_fin;
        // Pop strobes are gated by rst so nothing leaves the FIFOs while reset is held.
        assign w_len_rd = !rst && r_state == IDLE && en && !len_empty[i];
        assign w_acc    = r_valid && elem_ready[i];
        assign w_pop    = !rst && r_state == STREAM && !val_empty[i] && !col_empty[i] && (!r_valid || elem_ready[i]);
        assign w_fin    = r_state == ZERO || (r_state == DRAIN && w_acc);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= IDLE;
                r_rem   <= '0;
                r_val   <= '0;
                r_col   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_done <= w_fin;
                if (w_pop) begin
                    r_val   <= val_in[i*DATA_W +: DATA_W];
                    r_col   <= col_in[i*DATA_W +: DATA_W];
                    r_valid <= 1'b1;
                    r_last  <= r_rem == DATA_W'(1);
                    r_rem   <= r_rem - DATA_W'(1);
                end else if (w_acc) begin
                    r_valid <= 1'b0;
                end
                if (w_len_rd) begin
                    r_rem   <= len_in[i*DATA_W +: DATA_W];
                    r_state <= (len_in[i*DATA_W +: DATA_W] == '0) ? ZERO : STREAM;
                end else if (w_pop && r_rem == DATA_W'(1)) begin
                    r_state <= DRAIN;
                end else if (w_fin) begin
                    r_state <= IDLE;
                end
            end
        end
        assign len_read[i]                  = w_len_rd;
        assign val_read[i]                  = w_pop;
        assign col_read[i]                  = w_pop;
        assign elem_valid[i]                = r_valid;
        assign elem_last[i]                 = r_last;
        assign row_done[i]                  = r_done;
        assign elem_val[i*DATA_W +: DATA_W] = r_val;
        assign elem_col[i*DATA_W +: DATA_W] = r_col;
`ifdef ROW_SEQ_COUNT_EN
        logic [15:0] r_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_cnt <= '0;
            else if (w_fin) r_cnt <= r_cnt + 16'd1;
        end
        assign rows_cnt[i*16 +: 16] = r_cnt;
`endif
    end
endmodule

// File: tb/tb_row_sequencer.sv
// tb_row_sequencer: randomized scenarios against a row-stream reference model of row_sequencer.
// Honors ROW_SEQ_COUNT_EN to also check rows_cnt.
`timescale 1ns/1ps
module tb_row_sequencer;
    localparam int L  = 4;
    localparam int DW = 8;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [L*DW-1:0] val_in, col_in, len_in, elem_val, elem_col;
    logic [L-1:0] val_empty, col_empty, len_empty, val_read, col_read, len_read;
    logic [L-1:0] elem_valid, elem_ready, elem_last, row_done;
    logic [L-1:0] hold_val = '0, hold_col = '0;
`ifdef ROW_SEQ_COUNT_EN
    logic [L*16-1:0] rows_cnt;
`endif

    always #5 clk = ~clk;

    row_sequencer #(.LANES(L), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .val_in(val_in), .col_in(col_in), .len_in(len_in),
        .val_empty(val_empty), .col_empty(col_empty), .len_empty(len_empty),
        .val_read(val_read), .col_read(col_read), .len_read(len_read),
        .elem_valid(elem_valid), .elem_ready(elem_ready),
        .elem_val(elem_val), .elem_col(elem_col), .elem_last(elem_last),
        .row_done(row_done)
`ifdef ROW_SEQ_COUNT_EN
        , .rows_cnt(rows_cnt)
`endif
    );

    // Fetcher FIFO model and row-level reference streams
    logic [DW-1:0] qv[L][$], qc[L][$], ql[L][$];
    logic [2*DW:0] exp_q[L][$], got_q[L][$];
    int got_t[L][$], done_t[L][$];
    int exp_rows[L], total_rows[L];
    int cyc = 0, viol = 0, n_checks = 0, n_fail = 0;

    task automatic drive();
        for (int l = 0; l < L; l++) begin
            val_empty[l] = qv[l].size() == 0 || hold_val[l];
            col_empty[l] = qc[l].size() == 0 || hold_col[l];
            len_empty[l] = ql[l].size() == 0;
            val_in[l*DW +: DW] = qv[l].size() ? qv[l][0] : '0;
            col_in[l*DW +: DW] = qc[l].size() ? qc[l][0] : '0;
            len_in[l*DW +: DW] = ql[l].size() ? ql[l][0] : '0;
        end
    endtask

    // Monitor: samples after negedge, applies pops just after posedge
    initial begin
        logic [L-1:0] pv, pl;
        logic [L-1:0] prev_stall;
        logic [2*DW:0] prev_e[L];
        logic [2*DW:0] e;
        prev_stall = '0;
        drive();
        forever begin
            @(negedge clk);
            drive();
            #1;
            pv = val_read;
            pl = len_read;
            for (int l = 0; l < L; l++) begin
                e = {elem_val[l*DW +: DW], elem_col[l*DW +: DW], elem_last[l]};
                if (val_read[l] !== col_read[l]) viol++;
                if (val_read[l] && val_empty[l]) viol++;
                if (col_read[l] && col_empty[l]) viol++;
                if (len_read[l] && len_empty[l]) viol++;
                if (val_read[l] && elem_valid[l] && !elem_ready[l]) viol++;
                if (!rst && prev_stall[l] && (!elem_valid[l] || e !== prev_e[l])) viol++;
                prev_e[l] = e;
                prev_stall[l] = elem_valid[l] && !elem_ready[l];
                if (elem_valid[l] && elem_ready[l]) begin
                    got_q[l].push_back(e);
                    got_t[l].push_back(cyc);
                end
                if (row_done[l]) done_t[l].push_back(cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int l = 0; l < L; l++) begin
                if (pv[l] && qv[l].size()) void'(qv[l].pop_front());
                if (pv[l] && qc[l].size()) void'(qc[l].pop_front());
                if (pl[l] && ql[l].size()) void'(ql[l].pop_front());
            end
            drive();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic add_row(input int l, input int len, input int v0, input bit rnd);
        logic [DW-1:0] v, c;
        ql[l].push_back(DW'(len));
        for (int k = 0; k < len; k++) begin
            v = rnd ? DW'($urandom) : DW'(v0 * (k + 1));
            c = rnd ? DW'($urandom) : DW'(k + 1);
            qv[l].push_back(v);
            qc[l].push_back(c);
            exp_q[l].push_back({v, c, k == len - 1});
        end
        exp_rows[l]++;
        total_rows[l]++;
    endtask

    task automatic clear_log();
        for (int l = 0; l < L; l++) begin
            exp_q[l].delete(); got_q[l].delete(); got_t[l].delete(); done_t[l].delete();
            exp_rows[l] = 0;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            tick(1);
            ok = 1'b1;
            for (int l = 0; l < L; l++)
                if (got_q[l].size() != exp_q[l].size() || done_t[l].size() != exp_rows[l] ||
                    ql[l].size() != 0 || qv[l].size() != 0) ok = 1'b0;
        end
        tick(3);
    endtask

    task automatic test_reset();
        bit ok;
        en = 1'b1;
        elem_ready = '1;
        for (int l = 0; l < L; l++) add_row(l, 1 + int'($urandom_range(3)), 0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            n_checks++;
            if ({len_read, val_read, col_read, elem_valid, elem_last, row_done} !== '0 || elem_val !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want 0", {len_read, val_read, col_read, elem_valid, elem_last, row_done});
            end
        end
        rst = 1'b0;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_drain: timeout got 0 want 1"); end
        for (int l = 0; l < L; l++) begin
            n_checks++;
            if (got_q[l] != exp_q[l] || done_t[l].size() != exp_rows[l]) begin
                n_fail++;
                $display("FAIL reset_rows lane%0d: got %0d elems/%0d rows want %0d/%0d", l, got_q[l].size(), done_t[l].size(), exp_q[l].size(), exp_rows[l]);
            end
        end
    endtask

    task automatic test_basic_row();
        bit ok;
        clear_log();
        add_row(0, 3, 'h11, 1'b0);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_drain: timeout got 0 want 1"); end
        for (int k = 0; k < 3 && k < got_q[0].size(); k++) begin
            n_checks++;
            if (got_q[0][k] !== exp_q[0][k]) begin
                n_fail++;
                $display("FAIL basic_elem%0d: got %h want %h", k, got_q[0][k], exp_q[0][k]);
            end
        end
        n_checks++;
        if (got_q[0].size() != 3 || got_t[0][2] != got_t[0][0] + 2) begin
            n_fail++;
            $display("FAIL basic_consecutive: got %0d elems want 3 on consecutive cycles", got_q[0].size());
        end
        n_checks++;
        if (done_t[0].size() != 1) begin n_fail++; $display("FAIL basic_row_done: got %0d want 1", done_t[0].size()); end
`ifdef ROW_SEQ_COUNT_EN
        n_checks++;
        if (rows_cnt[15:0] !== 16'(total_rows[0])) begin
            n_fail++;
            $display("FAIL basic_rows_cnt: got %0d want %0d", rows_cnt[15:0], total_rows[0]);
        end
`endif
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_log();
        add_row(1, 0, 0, 1'b0);
        add_row(1, 1, 'h44, 1'b0);
        wait_drain(ok);
        n_checks++;
        if (!ok || got_q[1].size() != 1 || done_t[1].size() != 2) begin
            n_fail++;
            $display("FAIL zero_counts: got %0d elems/%0d rows want 1/2", got_q[1].size(), done_t[1].size());
        end else begin
            n_checks++;
            if (got_q[1][0] !== {8'h44, 8'h01, 1'b1}) begin
                n_fail++;
                $display("FAIL zero_elem: got %h want %h", got_q[1][0], {8'h44, 8'h01, 1'b1});
            end
            n_checks++;
            if (done_t[1][0] >= got_t[1][0]) begin
                n_fail++;
                $display("FAIL zero_order: got done@%0d elem@%0d want done first", done_t[1][0], got_t[1][0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_log();
        viol = 0;
        add_row(2, 4, 0, 1'b1);
        for (int c = 0; c < 200 && got_q[2].size() < 4; c++) begin
            elem_ready[2] = (c % 4 == 0) || (c % 4 == 3);
            tick(1);
        end
        elem_ready = '1;
        wait_drain(ok);
        n_checks++;
        if (!ok || got_q[2] != exp_q[2]) begin
            n_fail++;
            $display("FAIL bp_order: got %0d elems want %0d in order", got_q[2].size(), exp_q[2].size());
        end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL bp_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_staggered_empty();
        bit ok;
        clear_log();
        viol = 0;
        hold_col = '1;
        for (int l = 0; l < L; l++) add_row(l, 2, 0, 1'b1);
        tick(3);
        for (int l = 0; l < L; l++) begin
            hold_col[l] = 1'b0;
            tick(1);
        end
        wait_drain(ok);
        for (int l = 0; l < L; l++) begin
            n_checks++;
            if (!ok || got_q[l] != exp_q[l] || done_t[l].size() != 1) begin
                n_fail++;
                $display("FAIL stagger_lane%0d: got %0d elems want %0d", l, got_q[l].size(), exp_q[l].size());
            end
        end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL stagger_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_en_and_midrow_reset();
        bit ok;
        clear_log();
        add_row(3, 5, 0, 1'b1);
        add_row(3, 2, 0, 1'b1);
        tick(2);
        en = 1'b0;
        tick(20);
        n_checks++;
        if (got_q[3].size() != 5 || done_t[3].size() != 1 || ql[3].size() != 1) begin
            n_fail++;
            $display("FAIL en_hold: got %0d elems/%0d rows/%0d lens left want 5/1/1", got_q[3].size(), done_t[3].size(), ql[3].size());
        end
        en = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok || got_q[3] != exp_q[3]) begin
            n_fail++;
            $display("FAIL en_resume: got %0d elems want %0d", got_q[3].size(), exp_q[3].size());
        end
        clear_log();
        add_row(3, 5, 0, 1'b1);
        for (int c = 0; c < 50 && got_q[3].size() < 2; c++) begin
            @(negedge clk);
            #2;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({len_read, val_read, col_read, elem_valid, elem_last, row_done} !== '0 || elem_val !== '0 || elem_col !== '0) begin
            n_fail++;
            $display("FAIL midrow_reset: got %h want 0", {len_read, val_read, col_read, elem_valid, elem_last, row_done});
        end
`ifdef ROW_SEQ_COUNT_EN
        n_checks++;
        if (rows_cnt !== '0) begin n_fail++; $display("FAIL reset_rows_cnt: got %h want 0", rows_cnt); end
`endif
        for (int l = 0; l < L; l++) begin
            qv[l].delete(); qc[l].delete(); ql[l].delete();
            total_rows[l] = 0;
        end
        clear_log();
        tick(2);
        rst = 1'b0;
        add_row(3, 1, 0, 1'b1);
        wait_drain(ok);
        n_checks++;
        if (!ok || got_q[3] != exp_q[3] || done_t[3].size() != 1) begin
            n_fail++;
            $display("FAIL post_reset_row: got %0d elems/%0d rows want 1/1", got_q[3].size(), done_t[3].size());
        end
    endtask

    task automatic test_max_len();
        bit ok;
        clear_log();
        add_row(0, 255, 0, 1'b1);
        wait_drain(ok);
        n_checks++;
        if (!ok || got_q[0] != exp_q[0] || done_t[0].size() != 1) begin
            n_fail++;
            $display("FAIL max_len: got %0d elems/%0d rows want 255/1", got_q[0].size(), done_t[0].size());
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int b = 0; b < 3; b++) begin
            clear_log();
            viol = 0;
            for (int l = 0; l < L; l++)
                repeat (1 + $urandom_range(2)) add_row(l, int'($urandom_range(6)), 0, 1'b1);
            for (int c = 0; c < 150; c++) begin
                elem_ready = L'($urandom);
                hold_val = L'($urandom) & L'($urandom);
                hold_col = L'($urandom) & L'($urandom);
                en = ($urandom_range(3) != 0);
                tick(1);
            end
            elem_ready = '1;
            hold_val = '0;
            hold_col = '0;
            en = 1'b1;
            wait_drain(ok);
            for (int l = 0; l < L; l++) begin
                n_checks++;
                if (!ok || got_q[l] != exp_q[l] || done_t[l].size() != exp_rows[l]) begin
                    n_fail++;
                    $display("FAIL random%0d_lane%0d: got %0d elems/%0d rows want %0d/%0d", b, l, got_q[l].size(), done_t[l].size(), exp_q[l].size(), exp_rows[l]);
                end
            end
            n_checks++;
            if (viol != 0) begin n_fail++; $display("FAIL random%0d_protocol: got %0d violations want 0", b, viol); end
        end
`ifdef ROW_SEQ_COUNT_EN
        for (int l = 0; l < L; l++) begin
            n_checks++;
            if (rows_cnt[l*16 +: 16] !== 16'(total_rows[l])) begin
                n_fail++;
                $display("FAIL rows_cnt lane%0d: got %0d want %0d", l, rows_cnt[l*16 +: 16], total_rows[l]);
            end
        end
`endif
    endtask

    initial begin
        elem_ready = '1;
        for (int l = 0; l < L; l++) begin
            exp_rows[l] = 0;
            total_rows[l] = 0;
        end
        test_reset();
        test_basic_row();
        test_zero_len();
        test_backpressure();
        test_staggered_empty();
        test_en_and_midrow_reset();
        test_max_len();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
